sda_kernel_ctrl_reg_multi: RTL and testbench
============================================

# sda_kernel_ctrl_reg_multi

Parametrised kernel control register block driving NUM_CHAN action cores from one SDAccel control-register word space. It sits behind `sda_kernel_ctrl_reg_sel` on the reg_req/reg_ack bus. It generalises the single-channel run/done control to:
- per-channel enable masks and go/done handshakes;
- standard ap_ctrl bits, including auto-restart;
- a GIE/IER/ISR interrupt scheme;
- a completed-run counter.

## Interface
- NUM_CHAN, 4: number of action channels, 1..16.
- ADDR_WIDTH, 4: reg_addr width (word address).
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high reset.
- reg_req  in  1  register access request, held until reg_ack.
- reg_ack  out  1  one-cycle acknowledge. Reset 0.
- reg_write_en  in  1  1 = write, 0 = read; valid with reg_req.
- reg_addr  in  ADDR_WIDTH  word address.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid while reg_ack high. Reset 0.
- go_r  out  NUM_CHAN  per-channel start request. Reset 0.
- go_a  in  NUM_CHAN  per-channel start acknowledge.
- done_r  in  NUM_CHAN  per-channel completion request.
- done_a  out  NUM_CHAN  per-channel completion acknowledge. Reset 0.
- interrupt  out  1  registered level interrupt. Reset 0.

## Operation
Register map (word addresses); unmapped reads return 0 and unmapped writes are ignored; all are acked.
- 0 AP_CTRL
  - bit0 ap_start: W1 sets; writing 0 has no effect.
  - bit1 ap_done: clear-on-read.
  - bit2 ap_idle (RO).
  - bit3 ap_ready (RO): clear-on-read.
  - bit7 auto_restart (RW).
- 1 GIE: bit0.
- 2 IER: bit0 done, bit1 ready.
- 3 ISR: bit0 done, bit1 ready. Writing 1 toggles the bit.
- 4 CHAN_EN: [NUM_CHAN-1:0] RW, reset all ones.
- 5 CHAN_BUSY: RO.
- 6 RUN_COUNT: RO 32-bit count of completed runs, wraps at 2^32.

Bus handshake:
- Accept when reg_req is high and the block is not busy; the block becomes busy.
- reg_ack is high for exactly the cycle after the accept edge.
- The block stays busy until reg_req is sampled low. No second ack is issued for a held req.

Run control:
- Launch occurs when ap_start=1 and ap_idle=1. At launch, the run mask is snapshotted from CHAN_EN.
- CHAN_EN writes during a run affect the next run only.
- Per-channel sequencer states:
  - IDLE → GO_REQ on launch with mask bit set.
  - GO_REQ (go_r=1) → GO_RTZ when go_a=1.
  - GO_RTZ (go_r=0) → RUN when go_a=0.
  - RUN → DONE_ACK when done_r=1 (done_a=1).
  - DONE_ACK → IDLE when done_r=0 (done_a=0).
- ap_ready and ISR[1] are set on the edge where the last masked channel leaves GO_REQ.
  - ap_start clears at that edge unless auto_restart=1.
- ap_done and ISR[0] are set, and RUN_COUNT increments, on the edge where the last masked channel leaves DONE_ACK.
  - ap_idle becomes 1 at that edge.
- Empty mask at launch: ap_ready, ap_done, ISR[1:0] and RUN_COUNT all update on the launch edge. No go_r is asserted.
- auto_restart=1 with ap_start still 1 relaunches on the edge after completion.
- interrupt = GIE & |(IER & ISR), registered.
- Reset at any time: all sequencers return to IDLE, all registers go to reset values (CHAN_EN all ones, others 0), go_r/done_a drop immediately.

## Timing
- Write accepted at edge E0 → register value visible after E0, reg_ack high during E0→E1.
- ap_start written at E0 → go_r high after E1 (launch at E1).
- go_a sampled high at Ek → go_r low after Ek. ap_ready visible after Ek if that was the last channel.
- done_r sampled high at Ed → done_a high after Ed. done_r sampled low at Ef → done_a low after Ef.
- ap_done visible after Ef; interrupt high after Ef+1.
- Read of AP_CTRL clears ap_done/ap_ready at the accept edge. The returned data holds the pre-clear values.
- A set event coinciding with clear-on-read at the same edge: the set wins.
- An ISR toggle write coinciding with a hardware set: the result bit is 1.

## Structure
- Package `sda_kernel_ctrl_pkg`:
  - register word offsets;
  - AP_CTRL/ISR bit positions;
  - channel-sequencer state encoding (IDLE, GO_REQ, GO_RTZ, RUN, DONE_ACK).
- Sub-module `sda_kernel_chan_seq`: one channel's five-state go/done sequencer, generate-instantiated NUM_CHAN times. It outputs go_r, done_a, busy, left_go and left_done pulses.
- Top level holds the register file, bus handshake, run mask, aggregation and interrupt logic.

## Test plan
- NUM_CHAN=4, write AP_CTRL=0x1, each go_a responds 2 cycles after go_r, done_r pulsed per channel → four go_r rises after E1; ap_ready then ap_done set; RUN_COUNT=1; read AP_CTRL returns 0x0E, next read returns 0x04.
- CHAN_EN=0x5, start → only go_r[0] and go_r[2] assert. Channels 1 and 3 stay IDLE; ap_done waits only for 0 and 2.
- CHAN_EN=0 then start → ap_done=1, ap_ready=1, RUN_COUNT+1 on the launch edge; go_r stays 0.
- GIE=1, IER=0x1, run to completion → interrupt high 1 cycle after ap_done; ISR write 0x1 → interrupt low next cycle.
- auto_restart=1 plus start, run three completions → RUN_COUNT=3; go_r reasserts 1 cycle after each completion; clearing auto_restart and ap_start-cleared → idle after current run.
- Assert reset while channels are in RUN with done_a high → go_r/done_a/interrupt 0 immediately; CHAN_EN reads 0xF; RUN_COUNT reads 0.

Source files
------------

// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared definitions for the multi-channel kernel control block: register word
// offsets, AP_CTRL/ISR bit positions and the channel sequencer state encoding.
package sda_kernel_ctrl_pkg;

  localparam int REG_AP_CTRL   = 0;
  localparam int REG_GIE       = 1;
  localparam int REG_IER       = 2;
  localparam int REG_ISR       = 3;
  localparam int REG_CHAN_EN   = 4;
  localparam int REG_CHAN_BUSY = 5;
  localparam int REG_RUN_COUNT = 6;

  localparam int AP_START_BIT        = 0;
  localparam int AP_DONE_BIT         = 1;
  localparam int AP_IDLE_BIT         = 2;
  localparam int AP_READY_BIT        = 3;
  localparam int AP_AUTO_RESTART_BIT = 7;

  localparam int ISR_DONE_BIT  = 0;
  localparam int ISR_READY_BIT = 1;

  localparam int SEQ_W = 3;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_GO_REQ   = 3'd1,
    SEQ_GO_RTZ   = 3'd2,
    SEQ_RUN      = 3'd3,
    SEQ_DONE_ACK = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sda_kernel_chan_seq.sv
// One channel's go/done four-phase sequencer. Emits single-cycle pulses on the
// edges where it leaves GO_REQ and DONE_ACK so the top can aggregate them.
module sda_kernel_chan_seq
  import sda_kernel_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       launch,
  input  logic       go_a,
  input  logic       done_r,
  output logic       go_r,
  output logic       done_a,
  output logic       busy,
  output logic       left_go,
  output logic       left_done,
  output seq_state_e state
);

  seq_state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:     if (launch)  state_d = SEQ_GO_REQ;
      SEQ_GO_REQ:   if (go_a)    state_d = SEQ_GO_RTZ;
      SEQ_GO_RTZ:   if (!go_a)   state_d = SEQ_RUN;
      SEQ_RUN:      if (done_r)  state_d = SEQ_DONE_ACK;
      SEQ_DONE_ACK: if (!done_r) state_d = SEQ_IDLE;
      default:                   state_d = SEQ_IDLE;
    endcase
  end

  // Moore outputs, so go_r/done_a fall as soon as reset clears the state.
  always_comb begin
    go_r      = (state_q == SEQ_GO_REQ);
    done_a    = (state_q == SEQ_DONE_ACK);
    busy      = (state_q != SEQ_IDLE);
    left_go   = (state_q == SEQ_GO_REQ) && go_a;
    left_done = (state_q == SEQ_DONE_ACK) && !done_r;
  end

  assign state = state_q;

endmodule

// File: rtl/sda_kernel_ctrl_reg_multi.sv
// Control register block launching NUM_CHAN action cores from one ap_ctrl word,
// with GIE/IER/ISR interrupts and a completed-run counter.
module sda_kernel_ctrl_reg_multi
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int NUM_CHAN   = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_req,
  output logic                      reg_ack,
  input  logic                      reg_write_en,
  input  logic [ADDR_WIDTH-1:0]     reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic [NUM_CHAN-1:0]       go_r,
  input  logic [NUM_CHAN-1:0]       go_a,
  input  logic [NUM_CHAN-1:0]       done_r,
  output logic [NUM_CHAN-1:0]       done_a,
  output logic                      interrupt,
  output logic [NUM_CHAN*SEQ_W-1:0] dbg_chan_state
);

  // Bus handshake: a request is accepted when reg_req is high and no access is
  // in flight; reg_ack pulses the following cycle and the block ignores reg_req
  // until it is seen low, so a held request gets exactly one ack.
  logic        bus_busy, accept, wr_acc, rd_acc;
  logic [31:0] addr_ext, rd_mux, ap_ctrl_word;
  logic        unused_wdata;

  logic        ap_start, ap_done, ap_ready, auto_restart, running, gie;
  logic [1:0]  ier, isr;
  logic [31:0] run_count;
  logic [NUM_CHAN-1:0] chan_en, chan_busy, left_go, left_done, pend_go, pend_done;
  logic        launch, empty_launch, ready_evt, done_evt, ready_set, done_set;
  logic        wr_ap, rd_ap, wr_isr;

  assign accept       = reg_req && !bus_busy;
  assign wr_acc       = accept && reg_write_en;
  assign rd_acc       = accept && !reg_write_en;
  assign addr_ext     = 32'(reg_addr);
  assign unused_wdata = ^reg_wdata;
  assign wr_ap        = wr_acc && (addr_ext == 32'(REG_AP_CTRL));
  assign rd_ap        = rd_acc && (addr_ext == 32'(REG_AP_CTRL));
  assign wr_isr       = wr_acc && (addr_ext == 32'(REG_ISR));

  // Run mask is CHAN_EN sampled at launch; an empty mask completes on the spot.
  assign launch       = ap_start && !running;
  assign empty_launch = launch && (chan_en == '0);
  assign ready_evt    = (pend_go != '0) && ((pend_go & ~left_go) == '0);
  assign done_evt     = (pend_done != '0) && ((pend_done & ~left_done) == '0);
  assign ready_set    = ready_evt || empty_launch;
  assign done_set     = done_evt || empty_launch;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    seq_state_e st;
    sda_kernel_chan_seq u_seq (
      .clk       (clk),
      .reset     (reset),
      .launch    (launch && chan_en[g]),
      .go_a      (go_a[g]),
      .done_r    (done_r[g]),
      .go_r      (go_r[g]),
      .done_a    (done_a[g]),
      .busy      (chan_busy[g]),
      .left_go   (left_go[g]),
      .left_done (left_done[g]),
      .state     (st)
    );
    assign dbg_chan_state[g*SEQ_W +: SEQ_W] = st;
  end

  always_comb begin
    ap_ctrl_word                      = '0;
    ap_ctrl_word[AP_START_BIT]        = ap_start;
    ap_ctrl_word[AP_DONE_BIT]         = ap_done;
    ap_ctrl_word[AP_IDLE_BIT]         = !running;
    ap_ctrl_word[AP_READY_BIT]        = ap_ready;
    ap_ctrl_word[AP_AUTO_RESTART_BIT] = auto_restart;
  end

  always_comb begin
    rd_mux = '0;
    case (addr_ext)
      32'(REG_AP_CTRL):   rd_mux = ap_ctrl_word;
      32'(REG_GIE):       rd_mux = {31'd0, gie};
      32'(REG_IER):       rd_mux = {30'd0, ier};
      32'(REG_ISR):       rd_mux = {30'd0, isr};
      32'(REG_CHAN_EN):   rd_mux = 32'(chan_en);
      32'(REG_CHAN_BUSY): rd_mux = 32'(chan_busy);
      32'(REG_RUN_COUNT): rd_mux = run_count;
      default:            rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_busy     <= 1'b0;
      reg_ack      <= 1'b0;
      reg_rdata    <= '0;
      ap_start     <= 1'b0;
      ap_done      <= 1'b0;
      ap_ready     <= 1'b0;
      auto_restart <= 1'b0;
      running      <= 1'b0;
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
      chan_en      <= '1;
      run_count    <= '0;
      pend_go      <= '0;
      pend_done    <= '0;
      interrupt    <= 1'b0;
    end else begin
      reg_ack   <= accept;
      reg_rdata <= rd_acc ? rd_mux : '0;
      if (accept)        bus_busy <= 1'b1;
      else if (!reg_req) bus_busy <= 1'b0;

      // Hardware set events take priority over clear-on-read and ap_start clear.
      if (wr_ap && reg_wdata[AP_START_BIT])  ap_start <= 1'b1;
      else if (ready_set && !auto_restart)   ap_start <= 1'b0;
      if (done_set)                          ap_done  <= 1'b1;
      else if (rd_ap)                        ap_done  <= 1'b0;
      if (ready_set)                         ap_ready <= 1'b1;
      else if (rd_ap)                        ap_ready <= 1'b0;
      if (wr_ap) auto_restart <= reg_wdata[AP_AUTO_RESTART_BIT];

      if (wr_acc && addr_ext == 32'(REG_GIE))     gie     <= reg_wdata[0];
      if (wr_acc && addr_ext == 32'(REG_IER))     ier     <= reg_wdata[1:0];
      if (wr_acc && addr_ext == 32'(REG_CHAN_EN)) chan_en <= reg_wdata[NUM_CHAN-1:0];
      isr <= (isr ^ ({2{wr_isr}} & reg_wdata[1:0])) | {ready_set, done_set};

      if (launch) begin
        pend_go   <= chan_en;
        pend_done <= chan_en;
      end else begin
        pend_go   <= pend_go & ~left_go;
        pend_done <= pend_done & ~left_done;
      end
      if (launch && !empty_launch) running <= 1'b1;
      else if (done_evt)           running <= 1'b0;
      if (done_set) run_count <= run_count + 32'd1;

      interrupt <= gie && |(ier & isr);
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_reg_multi.sv
// Bench for sda_kernel_ctrl_reg_multi: register vector table, then hand-written
// run, empty-mask, interrupt, auto-restart and mid-run reset sequences.
module tb_sda_kernel_ctrl_reg_multi;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_req, reg_ack, reg_write_en;
  logic [3:0]    reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic [NC-1:0] go_r, go_a, done_r, done_a;
  logic          interrupt;
  logic [NC*3-1:0] dbg_chan_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        hold_done = 1'b0;
  int          go_rises[NC];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[25];

  sda_kernel_ctrl_reg_multi #(.NUM_CHAN(NC), .ADDR_WIDTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .reg_req        (reg_req),
    .reg_ack        (reg_ack),
    .reg_write_en   (reg_write_en),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_rdata      (reg_rdata),
    .go_r           (go_r),
    .go_a           (go_a),
    .done_r         (done_r),
    .done_a         (done_a),
    .interrupt      (interrupt),
    .dbg_chan_state (dbg_chan_state)
  );

  // Clock and watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "watchdog");
  end

  // Action-core model: go_a two cycles after go_r, done_r after 3+i run cycles.
  initial begin
    int phase[NC];
    int cnt[NC];
    go_a = '0;
    done_r = '0;
    for (int i = 0; i < NC; i++) begin phase[i] = 0; cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (reset) begin
          phase[i] = 0; cnt[i] = 0; go_a[i] = 1'b0; done_r[i] = 1'b0;
        end else begin
          case (phase[i])
            0: if (go_r[i]) begin
                 cnt[i]++;
                 if (cnt[i] == 2) begin go_a[i] = 1'b1; phase[i] = 1; end
               end
            1: if (!go_r[i]) begin go_a[i] = 1'b0; cnt[i] = 3 + i; phase[i] = 2; end
            2: begin
                 cnt[i]--;
                 if (cnt[i] == 0) begin done_r[i] = 1'b1; phase[i] = 3; end
               end
            default: if (done_a[i] && !hold_done) begin
                 done_r[i] = 1'b0; phase[i] = 0; cnt[i] = 0;
               end
          endcase
        end
      end
    end
  end

  // go_r rise counter per channel
  initial begin
    logic [NC-1:0] gprev;
    gprev = '0;
    for (int i = 0; i < NC; i++) go_rises[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) if (go_r[i] && !gprev[i]) go_rises[i]++;
      gprev = go_r;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                     input string name);
    logic got;
    got = 1'b0;
    reg_req = 1'b1; reg_write_en = we; reg_addr = addr; reg_wdata = wd;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (reg_ack) begin got = 1'b1; break; end
    end
    reg_req = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no ack within 8 cycles", name);
      if (!we) void'(exp_q.pop_front());
    end else if (!we) begin
      check(name, reg_rdata, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    bus(1'b1, addr, data, "write");
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    bus(1'b0, addr, 32'd0, name);
  endtask

  function automatic logic [NC-1:0] rise_mask(input int snap[NC]);
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) m[i] = (go_rises[i] != snap[i]);
    return m;
  endfunction

  initial begin
    int snap[NC];
    int acks, n_l;
    logic prev0, got;
    logic [NC-1:0] p1, p2;

    vecs[0]  = '{1'b0, 4'd4, 32'h0000000F};
    vecs[1]  = '{1'b0, 4'd6, 32'h00000000};
    vecs[2]  = '{1'b0, 4'd0, 32'h00000004};
    vecs[3]  = '{1'b0, 4'd5, 32'h00000000};
    vecs[4]  = '{1'b1, 4'd1, 32'h00000001};
    vecs[5]  = '{1'b0, 4'd1, 32'h00000001};
    vecs[6]  = '{1'b1, 4'd2, 32'h00000003};
    vecs[7]  = '{1'b0, 4'd2, 32'h00000003};
    vecs[8]  = '{1'b1, 4'd2, 32'h00000000};
    vecs[9]  = '{1'b1, 4'd1, 32'h00000000};
    vecs[10] = '{1'b0, 4'd1, 32'h00000000};
    vecs[11] = '{1'b1, 4'd4, 32'h000000A5};
    vecs[12] = '{1'b0, 4'd4, 32'h00000005};
    vecs[13] = '{1'b1, 4'd4, 32'h0000000F};
    vecs[14] = '{1'b1, 4'd9, 32'h0000FFFF};
    vecs[15] = '{1'b0, 4'd9, 32'h00000000};
    vecs[16] = '{1'b1, 4'd0, 32'h00000080};
    vecs[17] = '{1'b0, 4'd0, 32'h00000084};
    vecs[18] = '{1'b1, 4'd0, 32'h00000000};
    vecs[19] = '{1'b0, 4'd0, 32'h00000004};
    vecs[20] = '{1'b1, 4'd3, 32'h00000001};
    vecs[21] = '{1'b0, 4'd3, 32'h00000001};
    vecs[22] = '{1'b1, 4'd3, 32'h00000001};
    vecs[23] = '{1'b0, 4'd3, 32'h00000000};
    vecs[24] = '{1'b0, 4'd7, 32'h00000000};

    // Reset state
    reset = 1'b1; reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(reg_ack), 0);
    check("rst_rdata", reg_rdata, 0);
    check("rst_go_r", 32'(go_r), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_irq", 32'(interrupt), 0);
    check("rst_state", 32'(dbg_chan_state), 0);
    reset = 1'b0;
    @(negedge clk);

    // Register vector table
    for (int i = 0; i < 25; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // Held request is acknowledged once
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 4'd4;
    acks = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (reg_ack) acks++; end
    reg_req = 1'b0;
    @(negedge clk);
    check("held_req_acks", 32'(acks), 1);

    // Full four-channel run
    for (int i = 0; i < NC; i++) snap[i] = go_rises[i];
    reg_req = 1'b1; reg_write_en = 1'b1; reg_addr = 4'd0; reg_wdata = 32'h1;
    @(negedge clk);
    check("t1_ack", 32'(reg_ack), 1);
    check("t1_go_before_e1", 32'(go_r), 0);
    reg_req = 1'b0;
    @(negedge clk);
    check("t1_ack_single", 32'(reg_ack), 0);
    check("t1_go_after_e1", 32'(go_r), 32'hF);
    repeat (20) @(negedge clk);
    rd(4'd0, 32'h0E, "t1_ctrl");
    rd(4'd0, 32'h04, "t1_ctrl_cleared");
    rd(4'd6, 32'd1, "t1_count");
    check("t1_go_mask", 32'(rise_mask(snap)), 32'hF);

    // Partial mask 0x5
    for (int i = 0; i < NC; i++) snap[i] = go_rises[i];
    wr(4'd4, 32'h5);
    wr(4'd0, 32'h1);
    repeat (3) @(negedge clk);
    rd(4'd0, 32'h08, "t2_ctrl_mid");
    rd(4'd5, 32'h05, "t2_busy_mid");
    repeat (20) @(negedge clk);
    rd(4'd0, 32'h06, "t2_ctrl_done");
    rd(4'd0, 32'h04, "t2_ctrl_cleared");
    rd(4'd6, 32'd2, "t2_count");
    check("t2_go_mask", 32'(rise_mask(snap)), 32'h5);

    // Empty mask completes at launch
    for (int i = 0; i < NC; i++) snap[i] = go_rises[i];
    wr(4'd4, 32'h0);
    wr(4'd0, 32'h1);
    rd(4'd0, 32'h0E, "t3_ctrl");
    rd(4'd6, 32'd3, "t3_count");
    rd(4'd3, 32'h3, "t3_isr");
    check("t3_go_mask", 32'(rise_mask(snap)), 32'h0);

    // Done interrupt
    wr(4'd4, 32'hF);
    wr(4'd3, 32'h3);
    wr(4'd2, 32'h1);
    wr(4'd1, 32'h1);
    check("t4_irq_idle", 32'(interrupt), 0);
    wr(4'd0, 32'h1);
    p1 = '0; p2 = '0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (interrupt) begin got = 1'b1; break; end
      p2 = p1; p1 = done_a;
    end
    check("t4_irq_seen", 32'(got), 1);
    check("t4_irq_latency", {30'd0, p2 != '0, p1 == '0}, 32'h3);
    wr(4'd3, 32'h1);
    check("t4_irq_cleared", 32'(interrupt), 0);
    rd(4'd3, 32'h2, "t4_isr");

    // Auto-restart: three runs, clear auto_restart early in the third
    for (int i = 0; i < NC; i++) snap[i] = go_rises[i];
    rd(4'd0, 32'h0E, "t5_ctrl_pre");
    wr(4'd0, 32'h81);
    prev0 = 1'b0; p1 = '0; p2 = '0; n_l = 0;
    for (int k = 0; k < 200; k++) begin
      if (go_r[0] && !prev0) begin
        n_l++;
        if (n_l >= 2) check($sformatf("t5_relaunch%0d", n_l), {30'd0, p2 != '0, p1 == '0}, 32'h3);
      end
      prev0 = go_r[0]; p2 = p1; p1 = done_a;
      if (n_l == 3) break;
      @(negedge clk);
    end
    check("t5_launches", 32'(n_l), 3);
    wr(4'd0, 32'h00);
    repeat (25) @(negedge clk);
    rd(4'd6, 32'd7, "t5_count");
    rd(4'd0, 32'h0E, "t5_ctrl");
    check("t5_rises_ch0", 32'(go_rises[0] - snap[0]), 3);

    // Reset during DONE_ACK
    hold_done = 1'b1;
    wr(4'd0, 32'h1);
    repeat (15) @(negedge clk);
    check("t6_done_a_held", 32'(done_a), 32'hF);
    check("t6_irq_before", 32'(interrupt), 1);
    #1 reset = 1'b1;
    #1;
    check("t6_go_r_rst", 32'(go_r), 0);
    check("t6_done_a_rst", 32'(done_a), 0);
    check("t6_irq_rst", 32'(interrupt), 0);
    @(negedge clk);
    reset = 1'b0;
    hold_done = 1'b0;
    @(negedge clk);
    rd(4'd4, 32'hF, "t6_chan_en");
    rd(4'd6, 32'd0, "t6_count");
    rd(4'd0, 32'h04, "t6_ctrl");
    rd(4'd1, 32'h0, "t6_gie");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
